// File: rtl/mul51_term_accumulator_if.sv
// Term-beat input stream and accumulated-sum output stream
// of the 51x51 product accumulator.
interface mul51_term_accumulator_if #(
  parameter int ACC_W = 112,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [33:0]      term_34w;
  logic [50:0]      term_51w;
  logic [67:0]      term_68w;
  logic [101:0]     term_102w;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_first, in_last,
    output term_34w, term_51w,
    output term_68w, term_102w,
    output out_ready,
    input  in_ready, out_valid,
    input  out_data, out_count
  );

  modport slave (
    input  in_valid, in_first, in_last,
    input  term_34w, term_51w,
    input  term_68w, term_102w,
    input  out_ready,
    output in_ready, out_valid,
    output out_data, out_count
  );
endinterface

// File: rtl/mul51_term_accumulator.sv
// Sums the four aligned multiplier terms into a*b and
// accumulates products between first/last beat tags.
module mul51_term_accumulator #(
  parameter int ACC_W = 112,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  mul51_term_accumulator_if.slave bus,
  output logic err_seq
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  logic             adv;
  logic             v1_q;
  logic             first1_q;
  logic             last1_q;
  logic [33:0]      t34_q;
  logic [50:0]      t51_q;
  logic [67:0]      t68_q;
  logic [101:0]     t102_q;
  logic             v2_q;
  logic             first2_q;
  logic             last2_q;
  logic [101:0]     prod2_q;
  logic [101:0]     prod_d;
  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             seq_err;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             err_q;

  // One shared advance: the whole pipe freezes
  // while a produced sum waits for its consumer.
  assign adv           = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign err_seq       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      t34_q    <= '0;
      t51_q    <= '0;
      t68_q    <= '0;
      t102_q   <= '0;
    end else if (adv) begin
      v1_q     <= bus.in_valid;
      first1_q <= bus.in_first;
      last1_q  <= bus.in_last;
      t34_q    <= bus.term_34w;
      t51_q    <= bus.term_51w;
      t68_q    <= bus.term_68w;
      t102_q   <= bus.term_102w;
    end
  end

  always_comb begin
    prod_d = t102_q
           + (102'(t68_q) << 17)
           + (102'(t51_q) << 25)
           + (102'(t34_q) << 34);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      prod2_q  <= '0;
    end else if (adv) begin
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      prod2_q  <= prod_d;
    end
  end

  // A first tag or an idle machine restarts the sum;
  // the two disagreeing means the tag order broke.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    seq_err = (state_q == IDLE) ^ first2_q;
    if (first2_q || state_q == IDLE) begin
      acc_d = ACC_W'(prod2_q);
      cnt_d = CNT_W'(1);
    end else begin
      acc_d = acc_q + ACC_W'(prod2_q);
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else if (adv) begin
      if (v2_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        if (seq_err) begin
          err_q <= 1'b1;
        end
        if (last2_q) begin
          out_data_q  <= acc_d;
          out_count_q <= cnt_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end else begin
          out_valid_q <= 1'b0;
          state_q     <= ACCUM;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul51_term_accumulator.sv
// Bench for mul51_term_accumulator: directed table,
// stall/reset sequences and a random scoreboard run.
module tb_mul51_term_accumulator;
  localparam int AW = 112;
  localparam int CW = 4;

  typedef logic [AW-1:0] wide_t;

  typedef struct {
    logic [50:0] a;
    logic [50:0] b;
    bit          first;
    bit          last;
    wide_t       exp;
    int          cnt;
  } vec_t;

  typedef struct {
    wide_t data;
    int    cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_seq;

  always #5 clk = ~clk;

  mul51_term_accumulator_if #(.ACC_W(AW), .CNT_W(CW)) bus ();

  mul51_term_accumulator #(.ACC_W(AW), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .err_seq(err_seq)
  );

  int tot = 0;
  int bad = 0;
  int n_out = 0;

  // transaction-level reference model
  res_t        q[$];
  wide_t       m_acc = '0;
  wide_t       m_p = '0;
  int          m_cnt = 0;
  bit          m_open = 1'b0;
  bit          m_err = 1'b0;
  res_t        m_r;
  logic [50:0] cur_a = '0;
  logic [50:0] cur_b = '0;
  bit          rdone = 1'b0;

  task automatic chk(input string nm, input wide_t act,
                     input wide_t exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge rst_n) begin
    q.delete();
    m_open = 1'b0;
    m_err  = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.in_valid && bus.in_ready) begin
        m_p = wide_t'(cur_a) * wide_t'(cur_b);
        if (bus.in_first == !m_open) begin
        end else begin
          m_err = 1'b1;
        end
        if (bus.in_first || !m_open) begin
          m_acc = m_p;
          m_cnt = 1;
        end else begin
          m_acc = m_acc + m_p;
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
        if (bus.in_last) begin
          m_r.data = m_acc;
          m_r.cnt  = m_cnt;
          q.push_back(m_r);
          m_open = 1'b0;
        end else begin
          m_open = 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_extra_output", 1, 0);
        end else begin
          m_r = q.pop_front();
          chk("sb_data", bus.out_data, m_r.data);
          chk("sb_count", wide_t'(bus.out_count), m_r.cnt);
        end
        n_out++;
      end
    end
  end

  // Drives one beat with a random but exact term split of a*b.
  task automatic send_beat(input logic [50:0] a,
                           input logic [50:0] b,
                           input bit f, input bit l);
    wide_t rem;
    wide_t x;
    int k;
    cur_a = a;
    cur_b = b;
    rem = wide_t'(a) * wide_t'(b);
    x = wide_t'({$urandom, $urandom}) & ((wide_t'(1) << 34) - 1);
    if (x > (rem >> 34)) x = rem >> 34;
    bus.term_34w = x[33:0];
    rem = rem - (x << 34);
    x = wide_t'({$urandom, $urandom}) & ((wide_t'(1) << 51) - 1);
    if (x > (rem >> 25)) x = rem >> 25;
    bus.term_51w = x[50:0];
    rem = rem - (x << 25);
    x = wide_t'({$urandom, $urandom, $urandom})
      & ((wide_t'(1) << 68) - 1);
    if (x > (rem >> 17)) x = rem >> 17;
    bus.term_68w = x[67:0];
    rem = rem - (x << 17);
    bus.term_102w = rem[101:0];
    bus.in_first = f;
    bus.in_last = l;
    bus.in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 200);
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input wide_t ed,
                          input int ec, input int el);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    if (!bus.out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_data"}, bus.out_data, ed);
      chk({nm, "_count"}, wide_t'(bus.out_count), ec);
      if (el > 0) chk({nm, "_latency"}, k, el);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, q.size(), 0);
  endtask

  function automatic vec_t mk(input logic [50:0] a,
                              input logic [50:0] b,
                              input bit f, input bit l,
                              input wide_t e, input int c);
    vec_t v;
    v.a = a;
    v.b = b;
    v.first = f;
    v.last = l;
    v.exp = e;
    v.cnt = c;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    logic [50:0] amax;
    wide_t one;
    int n0;
    amax = 51'h7_FFFF_FFFF_FFFF;
    one = wide_t'(1);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    bus.term_34w = '0;
    bus.term_51w = '0;
    bus.term_68w = '0;
    bus.term_102w = '0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_count", bus.out_count, 0);
    chk("rel_err_seq", err_seq, 0);

    tv[0] = mk(amax, amax, 1, 1,
               (one << 102) - (one << 52) + 1, 1);
    tv[1] = mk(51'd3, 51'd5, 1, 0, 0, 0);
    tv[2] = mk(51'd7, 51'd11, 0, 0, 0, 0);
    tv[3] = mk(51'd1 << 50, 51'd4, 0, 1, (one << 52) + 92, 3);
    tv[4] = mk(51'd0, 51'd12345, 1, 1, 0, 1);
    tv[5] = mk(amax, 51'd1, 1, 1, (one << 51) - 1, 1);
    for (int i = 0; i < 6; i++) begin
      send_beat(tv[i].a, tv[i].b, tv[i].first, tv[i].last);
      if (tv[i].last)
        wait_out($sformatf("tv%0d", i), tv[i].exp, tv[i].cnt,
                 (i == 0) ? 3 : 0);
    end
    chk("tv_err_seq", err_seq, 0);

    for (int i = 0; i < 20; i++)
      send_beat(51'd1, 51'd1, i == 0, i == 19);
    wait_out("sat20", 20, 15, 0);

    n0 = n_out;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_beat(51'(i + 1), 51'd3, 1, 1);
      end
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!bus.out_valid && k < 20);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_hold_data", bus.out_data, 3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk("stall_delivered", n_out - n0, 4);

    fork
      begin
        for (int g = 0; g < 60; g++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int j = 0; j < len; j++) begin
            if ($urandom % 3 == 0)
              repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
              end
            send_beat(($urandom % 8 == 0) ? amax
                        : 51'({$urandom, $urandom}),
                      51'({$urandom, $urandom}),
                      j == 0, j == len - 1);
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom % 4) != 0;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("rand_drain");
    chk("rand_err_seq", err_seq, m_err);

    send_beat(51'd5, 51'd5, 1, 1);
    send_beat(51'd6, 51'd6, 1, 1);
    #1;
    rst_n = 1'b0;
    #2;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_data", bus.out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(51'd2, 51'd2, 1, 1);
    wait_out("after_rst", 4, 1, 3);

    send_beat(51'd6, 51'd7, 0, 1);
    wait_out("no_first", 42, 1, 0);
    chk("err_set", err_seq, 1);
    send_beat(51'd3, 51'd3, 1, 1);
    wait_out("legal1", 9, 1, 0);
    send_beat(51'd2, 51'd2, 1, 0);
    send_beat(51'd2, 51'd3, 0, 1);
    wait_out("legal2", 10, 2, 0);
    chk("err_sticky", err_seq, 1);
    chk("err_model", err_seq, m_err);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
